// File: rtl/exe_mem_pipe_reg_if.sv
// Bundle of the execute-to-memory boundary signals: E-stage inputs, stage
// controls, downstream status, and the registered M fields plus CC.
interface exe_mem_pipe_reg_if;
  logic        M_stall;
  logic        M_bubble;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic        e_cnd;
  logic [63:0] e_valE;
  logic [63:0] E_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  E_dstM;
  logic [2:0]  e_cf;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  cc;

  modport master (
    output M_stall, M_bubble, E_stat, E_icode, e_cnd, e_valE, E_valA,
           e_dstE, E_dstM, e_cf, m_stat, W_stat,
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );

  modport slave (
    input  M_stall, M_bubble, E_stat, E_icode, e_cnd, e_valE, E_valA,
           e_dstE, E_dstM, e_cf, m_stat, W_stat,
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, cc
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// Y86-64 M pipeline register with stall/bubble control, plus the
// architectural condition-code register gated by downstream exceptions.
module exe_mem_pipe_reg (
  input logic              clk,
  input logic              rst,
  exe_mem_pipe_reg_if.slave bus
);
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] INOP     = 4'h1;
  localparam logic [3:0] IOPQ     = 4'h6;
  localparam logic [2:0] SBUB     = 3'h0;
  localparam logic [2:0] SHLT     = 3'h2;
  localparam logic [2:0] SADR     = 3'h3;
  localparam logic [2:0] SINS     = 3'h4;
  localparam logic [2:0] CC_RESET = 3'b100;

  logic [2:0]  stat_q,  stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q,   cnd_d;
  logic [63:0] valE_q,  valE_d;
  logic [63:0] valA_q,  valA_d;
  logic [3:0]  dstE_q,  dstE_d;
  logic [3:0]  dstM_q,  dstM_d;
  logic [2:0]  cc_q,    cc_d;
  logic        set_cc;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

  // An excepting instruction further down must not let a younger OPq alter flags.
  assign set_cc = (bus.E_icode == IOPQ) && !is_exc(bus.m_stat) && !is_exc(bus.W_stat);

  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    if (bus.M_stall) begin
      stat_d = stat_q;
    end else if (bus.M_bubble) begin
      stat_d  = SBUB;
      icode_d = INOP;
      cnd_d   = 1'b0;
      valE_d  = 64'd0;
      valA_d  = 64'd0;
      dstE_d  = RNONE;
      dstM_d  = RNONE;
    end else begin
      stat_d  = bus.E_stat;
      icode_d = bus.E_icode;
      cnd_d   = bus.e_cnd;
      valE_d  = bus.e_valE;
      valA_d  = bus.E_valA;
      dstE_d  = bus.e_dstE;
      dstM_d  = bus.E_dstM;
    end
  end

  assign cc_d = set_cc ? bus.e_cf : cc_q;

  // M stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q  <= SBUB;
      icode_q <= INOP;
      cnd_q   <= 1'b0;
      valE_q  <= 64'd0;
      valA_q  <= 64'd0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      cc_q    <= CC_RESET;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      cc_q    <= cc_d;
    end
  end

  assign bus.M_stat  = stat_q;
  assign bus.M_icode = icode_q;
  assign bus.M_cnd   = cnd_q;
  assign bus.M_valE  = valE_q;
  assign bus.M_valA  = valA_q;
  assign bus.M_dstE  = dstE_q;
  assign bus.M_dstM  = dstM_q;
  assign bus.cc      = cc_q;
endmodule
